// File: rtl/jk_pkg.sv
// Shared defaults and FSM encoding for the JK-stage pattern detector.
package jk_pkg;

    localparam int       DEF_PATTERN_W = 4;
    localparam logic [3:0] DEF_PATTERN = 4'b1011;
    localparam int       DEF_CNT_W     = 8;

    typedef enum logic {
        ST_FILL,
        ST_ARMED
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; sat flags the stuck value.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat
);

    logic [W-1:0] cnt_inc;

    assign cnt_inc = cnt + W'(1);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (inc && !sat) begin
            cnt <= cnt_inc;
            sat <= &cnt_inc;
        end
    end

endmodule

// File: rtl/jk_pattern_detector.sv
// Overlapping serial pattern detector on the JK stage's Q stream, with a saturating match count.
// Define JK_TOGGLE_COUNT_EN to add toggle_cnt, a saturating count of Q changes between valid samples.
module jk_pattern_detector
    import jk_pkg::*;
#(
    parameter int                   PATTERN_W = DEF_PATTERN_W,
    parameter logic [PATTERN_W-1:0] PATTERN   = DEF_PATTERN,
    parameter int                   CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             q_in,
    input  logic             q_valid,
    input  logic             clear,
    output logic             armed,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
`ifdef JK_TOGGLE_COUNT_EN
    ,
    output logic [CNT_W-1:0] toggle_cnt
`endif
);

    localparam int                FILL_W    = $clog2(PATTERN_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W);

    state_t               state;
    logic [PATTERN_W-1:0] history;
    logic [PATTERN_W-1:0] next_history;
    logic [FILL_W-1:0]    fill;
    logic [FILL_W-1:0]    next_fill;
    logic                 take;
    logic                 hit;

    // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
    always_comb begin
        take         = q_valid && !clear;
        next_history = {history[PATTERN_W-2:0], q_in};
        next_fill    = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
        // The cycle that completes the fill already counts as armed.
        hit          = take && ((state == ST_ARMED) || (next_fill == FILL_FULL))
                       && (next_history == PATTERN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_FILL;
            history <= '0;
            fill    <= '0;
            armed   <= 1'b0;
            match   <= 1'b0;
        end else if (clear) begin
            state   <= ST_FILL;
            history <= '0;
            fill    <= '0;
            armed   <= 1'b0;
            match   <= 1'b0;
        end else begin
            match <= hit;
            if (q_valid) begin
                history <= next_history;
                fill    <= next_fill;
                if (state == ST_FILL && next_fill == FILL_FULL) begin
                    state <= ST_ARMED;
                    armed <= 1'b1;
                end
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clear),
        .inc (hit),
        .cnt (match_cnt),
        .sat (cnt_sat)
    );

`ifdef JK_TOGGLE_COUNT_EN
    logic toggle_sat;
    logic toggle_inc;

    // history[0] is the previous valid sample; fill==0 means there is none yet.
    assign toggle_inc = take && (fill != '0) && (q_in != history[0]) && !toggle_sat;

    sat_counter #(.W(CNT_W)) u_toggle_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clear),
        .inc (toggle_inc),
        .cnt (toggle_cnt),
        .sat (toggle_sat)
    );
`endif

endmodule

// File: tb/tb_jk_pattern_detector.sv
// Self-checking bench for jk_pattern_detector: table vectors, corner sequences, random stream vs model.
module tb_jk_pattern_detector;

    localparam int         PW  = 4;
    localparam logic [3:0] PAT = 4'b1011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic q_in = 1'b0;
    logic q_valid = 1'b0;
    logic clear = 1'b0;

    logic       armed, match, cnt_sat;
    logic [7:0] match_cnt;
    logic       armed_s, match_s, cnt_sat_s;
    logic [1:0] match_cnt_s;
`ifdef JK_TOGGLE_COUNT_EN
    logic [7:0] toggle_cnt;
    logic [1:0] toggle_cnt_s;
`endif

    always #5 clk = ~clk;

    jk_pattern_detector #(.PATTERN_W(PW), .PATTERN(PAT), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .q_in      (q_in),
        .q_valid   (q_valid),
        .clear     (clear),
        .armed     (armed),
        .match     (match),
        .match_cnt (match_cnt),
        .cnt_sat   (cnt_sat)
`ifdef JK_TOGGLE_COUNT_EN
        ,
        .toggle_cnt(toggle_cnt)
`endif
    );

    jk_pattern_detector #(.PATTERN_W(PW), .PATTERN(PAT), .CNT_W(2)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .q_in      (q_in),
        .q_valid   (q_valid),
        .clear     (clear),
        .armed     (armed_s),
        .match     (match_s),
        .match_cnt (match_cnt_s),
        .cnt_sat   (cnt_sat_s)
`ifdef JK_TOGGLE_COUNT_EN
        ,
        .toggle_cnt(toggle_cnt_s)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: remembers the last PW valid samples since reset/clear.
    bit hist_q[$];
    int m_match, m_cnt, m_cnt_s, m_tog;

    function automatic int sat_add(input int v, input int max);
        return (v + 1 > max) ? max : v + 1;
    endfunction

    task automatic model_reset();
        hist_q.delete();
        m_match = 0; m_cnt = 0; m_cnt_s = 0; m_tog = 0;
    endtask

    task automatic model_step(input bit v, input bit q, input bit clr);
        int val;
        m_match = 0;
        if (clr) begin
            model_reset();
        end else if (v) begin
            if (hist_q.size() > 0 && hist_q[hist_q.size()-1] != q) m_tog = sat_add(m_tog, 255);
            hist_q.push_back(q);
            if (hist_q.size() > PW) void'(hist_q.pop_front());
            if (hist_q.size() == PW) begin
                val = 0;
                foreach (hist_q[i]) val = val * 2 + int'(hist_q[i]);
                m_match = (val == int'(PAT)) ? 1 : 0;
            end
            if (m_match != 0) begin
                m_cnt   = sat_add(m_cnt, 255);
                m_cnt_s = sat_add(m_cnt_s, 3);
            end
        end
    endtask

    task automatic compare_model();
        int m_armed;
        m_armed = (hist_q.size() == PW) ? 1 : 0;
        check("match",       int'(match),       m_match);
        check("armed",       int'(armed),       m_armed);
        check("match_cnt",   int'(match_cnt),   m_cnt);
        check("cnt_sat",     int'(cnt_sat),     (m_cnt == 255) ? 1 : 0);
        check("match_cnt_s", int'(match_cnt_s), m_cnt_s);
        check("cnt_sat_s",   int'(cnt_sat_s),   (m_cnt_s == 3) ? 1 : 0);
`ifdef JK_TOGGLE_COUNT_EN
        check("toggle_cnt",  int'(toggle_cnt),  m_tog);
`endif
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
    task automatic step(input bit v, input bit q, input bit clr);
        q_valid = v; q_in = q; clear = clr;
        @(posedge clk);
        #1;
        model_step(v, q, clr);
        compare_model();
        q_valid = 1'b0; clear = 1'b0;
    endtask

    task automatic send_bits(input logic [3:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], 1'b0);
    endtask

    typedef struct {
        bit v;
        bit q;
        bit clr;
        bit exp_match;
        int exp_cnt;
        bit exp_armed;
    } vec_t;

    vec_t vecs[17];

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;

        // Basic match, idle, clear-with-sample, then 1,0,<gap x3>,1,1,0,1,1 overlapping.
        vecs[0]  = '{1, 1, 0, 0, 0, 0};
        vecs[1]  = '{1, 0, 0, 0, 0, 0};
        vecs[2]  = '{1, 1, 0, 0, 0, 0};
        vecs[3]  = '{1, 1, 0, 1, 1, 1};
        vecs[4]  = '{0, 0, 0, 0, 1, 1};
        vecs[5]  = '{0, 0, 0, 0, 1, 1};
        vecs[6]  = '{1, 0, 1, 0, 0, 0};
        vecs[7]  = '{1, 1, 0, 0, 0, 0};
        vecs[8]  = '{1, 0, 0, 0, 0, 0};
        vecs[9]  = '{0, 1, 0, 0, 0, 0};
        vecs[10] = '{0, 1, 0, 0, 0, 0};
        vecs[11] = '{0, 0, 0, 0, 0, 0};
        vecs[12] = '{1, 1, 0, 0, 0, 0};
        vecs[13] = '{1, 1, 0, 1, 1, 1};
        vecs[14] = '{1, 0, 0, 0, 1, 1};
        vecs[15] = '{1, 1, 0, 0, 1, 1};
        vecs[16] = '{1, 1, 0, 1, 2, 1};

        // Reset state, before any clock edge.
        #3;
        check("rst_armed",     int'(armed),     0);
        check("rst_match",     int'(match),     0);
        check("rst_match_cnt", int'(match_cnt), 0);
        check("rst_cnt_sat",   int'(cnt_sat),   0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].q, vecs[i].clr);
            check($sformatf("vec%0d_match", i), int'(match),     int'(vecs[i].exp_match));
            check($sformatf("vec%0d_cnt", i),   int'(match_cnt), vecs[i].exp_cnt);
            check($sformatf("vec%0d_armed", i), int'(armed),     int'(vecs[i].exp_armed));
        end

        // Saturation on the 2-bit counter: 1011 five times.
        step(1'b0, 1'b0, 1'b1);
        pulses = 0;
        for (int rep = 0; rep < 5; rep++) begin
            for (int b = 3; b >= 0; b--) begin
                step(1'b1, PAT[b], 1'b0);
                pulses += int'(match_s);
            end
            check("sat_cnt",  int'(match_cnt_s), (rep + 1 > 3) ? 3 : rep + 1);
            check("sat_flag", int'(cnt_sat_s),   (rep >= 2) ? 1 : 0);
        end
        check("sat_pulses", pulses, 5);
        check("sat_wide_cnt", int'(match_cnt), 5);

        // Async reset mid-stream: history 1,0,1 must not combine with a later 1.
        send_bits(4'b0101, 3);
        #3;
        rst = 1'b1;
        #1;
        check("arst_armed",     int'(armed),       0);
        check("arst_match_cnt", int'(match_cnt),   0);
        check("arst_cnt_s",     int'(match_cnt_s), 0);
        check("arst_cnt_sat_s", int'(cnt_sat_s),   0);
        check("arst_match",     int'(match),       0);
        #1;
        rst = 1'b0;
        model_reset();
        step(1'b1, 1'b1, 1'b0);
        check("arst_no_match", int'(match), 0);
        check("arst_not_armed", int'(armed), 0);

        // Clear colliding with a valid sample: the sample is dropped.
        step(1'b0, 1'b0, 1'b1);
        send_bits(4'b1011, 4);
        check("clr_pre_cnt", int'(match_cnt), 1);
        step(1'b1, 1'b1, 1'b1);
        check("clr_cnt",   int'(match_cnt), 0);
        check("clr_armed", int'(armed),     0);
        pulses = 0;
        for (int b = 2; b >= 0; b--) begin
            step(1'b1, PAT[b], 1'b0);
            pulses += int'(match);
        end
        check("clr_discard_no_match", pulses, 0);
        send_bits(4'b1011, 4);
        check("clr_full_match", int'(match), 1);
        check("clr_full_cnt",   int'(match_cnt), 1);

`ifdef JK_TOGGLE_COUNT_EN
        step(1'b0, 1'b0, 1'b1);
        send_bits(4'b0101, 4);
        step(1'b1, 1'b1, 1'b0);
        check("toggle_cnt_3", int'(toggle_cnt), 3);
        step(1'b0, 1'b0, 1'b1);
        check("toggle_cnt_clr", int'(toggle_cnt), 0);
`endif

        // Random stream against the model, with occasional clears.
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 59) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
